// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round controller.
// Card ranks are 4-bit: 0 = empty, 1 = Ace .. 13 = King.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_P1     = 4'd1,
    S_D1     = 4'd2,
    S_P2     = 4'd3,
    S_D2     = 4'd4,
    S_EVAL   = 4'd5,
    S_P3     = 4'd6,
    S_BANK   = 4'd7,
    S_D3     = 4'd8,
    S_RESULT = 4'd9,
    S_DONE   = 4'd10
  } state_e;

  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

  // Face cards, tens and empty slots all count zero
  function automatic logic [3:0] card_value(
    input logic [3:0] rank
  );
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

endpackage

// File: rtl/baccarat_fsm_banker_draw.sv
// Banker third-card rule, given the banker total and the
// point value of the player's third card.
module banker_draw
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] v,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    unique case (1'b1)
      (dscore <= 4'd2): draw = 1'b1;
      (dscore == 4'd3): draw = (v != 4'd8);
      (dscore == 4'd4):
        draw = (v >= 4'd2) && (v <= 4'd7);
      (dscore == 4'd5):
        draw = (v >= 4'd4) && (v <= 4'd7);
      (dscore == 4'd6):
        draw = (v >= 4'd6) && (v <= 4'd7);
      default: draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_fsm.sv
// One-round baccarat sequencer: deals cards, applies the
// third-card rules and latches the win lights.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light
);

  localparam logic [3:0] BANKER_DRAW_MAX = 4'd5;

  state_e     state_q, state_d;
  logic       pwin_q, pwin_d;
  logic       dwin_q, dwin_d;
  logic       bank_draw;
  logic [3:0] p3_val;

  assign p3_val = card_value(pcard3);

  banker_draw u_banker_draw (
    .dscore (dscore),
    .v      (p3_val),
    .draw   (bank_draw)
  );

  // Card registers capture on the falling edge too
  always_ff @(negedge slow_clock) begin
    if (resetb) begin
      state_q <= S_RST;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pwin_d      = pwin_q;
    dwin_d      = dwin_q;
    load_pcard1 = 1'b0;
    load_pcard2 = 1'b0;
    load_pcard3 = 1'b0;
    load_dcard1 = 1'b0;
    load_dcard2 = 1'b0;
    load_dcard3 = 1'b0;
    case (state_q)
      S_RST: state_d = S_P1;
      S_P1: begin
        load_pcard1 = 1'b1;
        state_d     = S_D1;
      end
      S_D1: begin
        load_dcard1 = 1'b1;
        state_d     = S_P2;
      end
      S_P2: begin
        load_pcard2 = 1'b1;
        state_d     = S_D2;
      end
      S_D2: begin
        load_dcard2 = 1'b1;
        state_d     = S_EVAL;
      end
      S_EVAL: begin
        if (pscore >= NATURAL_MIN ||
            dscore >= NATURAL_MIN)
          state_d = S_RESULT;
        else if (pscore < PLAYER_STAND_MIN)
          state_d = S_P3;
        else if (dscore <= BANKER_DRAW_MAX)
          state_d = S_D3;
        else
          state_d = S_RESULT;
      end
      S_P3: begin
        load_pcard3 = 1'b1;
        state_d     = S_BANK;
      end
      S_BANK:
        state_d = bank_draw ? S_D3 : S_RESULT;
      S_D3: begin
        load_dcard3 = 1'b1;
        state_d     = S_RESULT;
      end
      S_RESULT: begin
        // A tie lights both
        pwin_d  = (pscore >= dscore);
        dwin_d  = (dscore >= pscore);
        state_d = S_DONE;
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_RST;
    endcase
  end

  assign player_win_light = pwin_q;
  assign dealer_win_light = dwin_q;

endmodule

// File: tb/tb_baccarat_fsm.sv
// Directed bench for baccarat_fsm with a behavioural model
// of the six card registers and the two scorers.
module tb_baccarat_fsm;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b1;
  logic [3:0] pscore, dscore, pcard3;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light;

  logic [3:0] dk_p1, dk_p2, dk_p3, dk_d1, dk_d2, dk_d3;
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;
  logic [5:0] stb;
  logic [1:0] lights;

  logic [3:0] bd_d, bd_v;
  logic       bd_draw;

  int checks = 0;
  int errors = 0;

  always #5 slow_clock = ~slow_clock;

  baccarat_fsm dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light)
  );

  banker_draw u_bd (
    .dscore (bd_d),
    .v      (bd_v),
    .draw   (bd_draw)
  );

  function automatic int val(input logic [3:0] r);
    if (r >= 4'd1 && r <= 4'd9) return int'(r);
    return 0;
  endfunction

  always @(negedge slow_clock) begin
    if (resetb) begin
      pc1 <= 0; pc2 <= 0; pc3 <= 0;
      dc1 <= 0; dc2 <= 0; dc3 <= 0;
    end else begin
      if (load_pcard1) pc1 <= dk_p1;
      if (load_pcard2) pc2 <= dk_p2;
      if (load_pcard3) pc3 <= dk_p3;
      if (load_dcard1) dc1 <= dk_d1;
      if (load_dcard2) dc2 <= dk_d2;
      if (load_dcard3) dc3 <= dk_d3;
    end
  end

  assign pscore = 4'((val(pc1) + val(pc2) + val(pc3)) % 10);
  assign dscore = 4'((val(dc1) + val(dc2) + val(dc3)) % 10);
  assign pcard3 = pc3;
  assign stb = {load_pcard1, load_dcard1, load_pcard2,
                load_dcard2, load_pcard3, load_dcard3};
  assign lights = {player_win_light, dealer_win_light};

  task automatic tick;
    @(negedge slow_clock);
    @(posedge slow_clock);
  endtask

  // Reset, release, and stop sampling in S_P1 (edge 0)
  task automatic deal(input logic [3:0] p1, p2, p3,
                      input logic [3:0] d1, d2, d3);
    dk_p1 = p1; dk_p2 = p2; dk_p3 = p3;
    dk_d1 = d1; dk_d2 = d2; dk_d3 = d3;
    resetb = 1'b1;
    tick; tick;
    resetb = 1'b0;
    tick;
    checks++;
    if (stb !== 6'b100000) begin
      errors++;
      $display("FAIL deal_p1: got %b expected 100000", stb);
    end
  endtask

  task automatic test_reset;
    resetb = 1'b1;
    tick; tick;
    checks++;
    if ({stb, lights} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {stb, lights});
    end
  endtask

  task automatic test_natural;
    logic [5:0] es [1:6];
    es = '{6'b010000, 6'b001000, 6'b000100, 0, 0, 0};
    deal(4'd1, 4'd7, 4'd0, 4'd2, 4'd3, 4'd0);
    for (int e = 1; e <= 6; e++) begin
      tick;
      checks++;
      if (stb !== es[e]) begin
        errors++;
        $display("FAIL nat_p_stb e%0d: got %b expected %b",
                 e, stb, es[e]);
      end
      checks++;
      if (lights !== (e == 6 ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL nat_p_lights e%0d: got %b", e, lights);
      end
    end
    deal(4'd1, 4'd1, 4'd0, 4'd4, 4'd4, 4'd0);
    for (int e = 1; e <= 6; e++) begin
      tick;
      checks++;
      if (stb !== es[e]) begin
        errors++;
        $display("FAIL nat_b_stb e%0d: got %b expected %b",
                 e, stb, es[e]);
      end
      checks++;
      if (lights !== (e == 6 ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL nat_b_lights e%0d: got %b", e, lights);
      end
    end
  endtask

  task automatic test_player_draw;
    logic [5:0] es [1:8];
    es = '{6'b010000, 6'b001000, 6'b000100, 0,
           6'b000010, 0, 0, 0};
    deal(4'd1, 4'd2, 4'd5, 4'd3, 4'd4, 4'd9);
    for (int e = 1; e <= 8; e++) begin
      tick;
      checks++;
      if (stb !== es[e]) begin
        errors++;
        $display("FAIL pdraw_stb e%0d: got %b expected %b",
                 e, stb, es[e]);
      end
      checks++;
      if (lights !== (e == 8 ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL pdraw_lights e%0d: got %b", e, lights);
      end
    end
  endtask

  task automatic test_banker_rule;
    logic [5:0] ea [1:9];
    logic [5:0] eb [1:8];
    logic       exp;
    ea = '{6'b010000, 6'b001000, 6'b000100, 0,
           6'b000010, 0, 6'b000001, 0, 0};
    eb = '{6'b010000, 6'b001000, 6'b000100, 0,
           6'b000010, 0, 0, 0};
    // B=6, pcard3=6: banker draws a 3, 9 vs 9 tie
    deal(4'd1, 4'd2, 4'd6, 4'd2, 4'd4, 4'd3);
    for (int e = 1; e <= 9; e++) begin
      tick;
      checks++;
      if (stb !== ea[e]) begin
        errors++;
        $display("FAIL bank6_stb e%0d: got %b expected %b",
                 e, stb, ea[e]);
      end
      checks++;
      if (lights !== (e == 9 ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL bank6_lights e%0d: got %b", e, lights);
      end
    end
    // pcard3 = Queen counts zero: banker stands on 6
    deal(4'd1, 4'd2, 4'd12, 4'd2, 4'd4, 4'd3);
    for (int e = 1; e <= 8; e++) begin
      tick;
      checks++;
      if (stb !== eb[e]) begin
        errors++;
        $display("FAIL bankq_stb e%0d: got %b expected %b",
                 e, stb, eb[e]);
      end
      checks++;
      if (lights !== (e == 8 ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL bankq_lights e%0d: got %b", e, lights);
      end
    end
    for (int d = 0; d <= 7; d++) begin
      for (int v = 0; v <= 9; v++) begin
        bd_d = 4'(d);
        bd_v = 4'(v);
        case (d)
          0, 1, 2: exp = 1'b1;
          3:       exp = (v != 8);
          4:       exp = (v > 1 && v < 8);
          5:       exp = (v > 3 && v < 8);
          6:       exp = (v == 6 || v == 7);
          default: exp = 1'b0;
        endcase
        #1;
        checks++;
        if (bd_draw !== exp) begin
          errors++;
          $display("FAIL sweep d%0d v%0d: got %b expected %b",
                   d, v, bd_draw, exp);
        end
      end
    end
  endtask

  task automatic test_tie;
    logic [5:0] es [1:6];
    es = '{6'b010000, 6'b001000, 6'b000100, 0, 0, 0};
    deal(4'd3, 4'd4, 4'd0, 4'd2, 4'd5, 4'd0);
    for (int e = 1; e <= 6; e++) begin
      tick;
      checks++;
      if (stb !== es[e]) begin
        errors++;
        $display("FAIL tie_stb e%0d: got %b expected %b",
                 e, stb, es[e]);
      end
      checks++;
      if (lights !== (e == 6 ? 2'b11 : 2'b00)) begin
        errors++;
        $display("FAIL tie_lights e%0d: got %b", e, lights);
      end
    end
    for (int e = 7; e <= 26; e++) begin
      tick;
      checks++;
      if ({stb, lights} !== 8'b00000011) begin
        errors++;
        $display("FAIL tie_hold e%0d: got %b expected 00000011",
                 e, {stb, lights});
      end
    end
    resetb = 1'b1;
    tick;
    checks++;
    if ({stb, lights} !== 8'h00) begin
      errors++;
      $display("FAIL done_reset: got %b expected 0",
               {stb, lights});
    end
    resetb = 1'b0;
  endtask

  task automatic test_banker_only;
    logic [5:0] es [1:7];
    es = '{6'b010000, 6'b001000, 6'b000100, 0,
           6'b000001, 0, 0};
    deal(4'd2, 4'd4, 4'd9, 4'd1, 4'd3, 4'd13);
    for (int e = 1; e <= 7; e++) begin
      tick;
      checks++;
      if (stb !== es[e]) begin
        errors++;
        $display("FAIL bonly_stb e%0d: got %b expected %b",
                 e, stb, es[e]);
      end
      checks++;
      if (lights !== (e == 7 ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL bonly_lights e%0d: got %b", e, lights);
      end
    end
  endtask

  task automatic test_reset_mid;
    deal(4'd1, 4'd2, 4'd5, 4'd3, 4'd4, 4'd0);
    for (int e = 1; e <= 5; e++) tick;
    checks++;
    if (stb !== 6'b000010) begin
      errors++;
      $display("FAIL mid_in_p3: got %b expected 000010", stb);
    end
    resetb = 1'b1;
    for (int e = 0; e < 2; e++) begin
      tick;
      checks++;
      if ({stb, lights} !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset %0d: got %b expected 0",
                 e, {stb, lights});
      end
    end
    resetb = 1'b0;
    tick;
    checks++;
    if (stb !== 6'b100000) begin
      errors++;
      $display("FAIL mid_restart: got %b expected 100000", stb);
    end
    tick;
    checks++;
    if (stb !== 6'b010000) begin
      errors++;
      $display("FAIL mid_next: got %b expected 010000", stb);
    end
  endtask

  initial begin
    dk_p1 = 0; dk_p2 = 0; dk_p3 = 0;
    dk_d1 = 0; dk_d2 = 0; dk_d3 = 0;
    bd_d = 0; bd_v = 0;
    test_reset;
    test_natural;
    test_player_draw;
    test_banker_rule;
    test_tie;
    test_banker_only;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
